// File: rtl/simd_mem_pkg.sv
// Types shared by the vector memory sequencer, its interface and the register-file side.
package simd_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LANES  = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_t;

    typedef logic [LANES-1:0][DATA_W-1:0] lane_array_t;

endpackage

// File: rtl/vec_mem_sequencer_if.sv
// Request/response and scalar memory-port signals of the vector load/store sequencer.
interface vec_mem_sequencer_if #(
    parameter int unsigned dataSize       = 32,
    parameter int unsigned addressingSize = 32,
    parameter int unsigned lanes          = 4
);
    logic                            start;
    logic                            is_store;
    logic [addressingSize-1:0]       base_addr;
    logic [lanes-1:0][dataSize-1:0]  store_data;
    logic [lanes-1:0][dataSize-1:0]  load_data;
    logic                            busy;
    logic                            done;
    logic                            mem_we;
    logic [addressingSize-1:0]       mem_addr;
    logic [dataSize-1:0]             mem_wdata;
    logic [dataSize-1:0]             mem_rdata;

    modport master (
        input  start, is_store, base_addr, store_data, mem_rdata,
        output load_data, busy, done, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output start, is_store, base_addr, store_data, mem_rdata,
        input  load_data, busy, done, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory; reads return one cycle after the address, vecSize words per access.
module data_memory #(
    parameter int unsigned dataSize       = 32,
    parameter int unsigned addressingSize = 32,
    parameter int unsigned memorySize     = 10020,
    parameter int unsigned vecSize        = 1
) (
    input  logic                         clk,
    input  logic                         write_enable,
    input  logic [addressingSize-1:0]    DataAdr,
    input  logic [dataSize*vecSize-1:0]  toWrite_data,
    output logic [dataSize*vecSize-1:0]  read_data
);
    localparam int unsigned MW = (memorySize > 1) ? $clog2(memorySize) : 1;

    logic [dataSize-1:0] mem [memorySize];

    // Addresses beyond memorySize alias back into the array.
    function automatic logic [MW-1:0] word_idx(input logic [addressingSize-1:0] a,
                                               input int unsigned v);
        return MW'((64'(a) + 64'(v)) % 64'(memorySize));
    endfunction

    generate
        if (vecSize == 1) begin : g_scalar
            always_ff @(posedge clk) begin
                if (write_enable)
                    mem[word_idx(DataAdr, 0)] <= toWrite_data;
                read_data <= mem[word_idx(DataAdr, 0)];
            end
        end else begin : g_vector
            always_ff @(posedge clk) begin
                for (int unsigned v = 0; v < vecSize; v++) begin
                    if (write_enable)
                        mem[word_idx(DataAdr, v)] <= toWrite_data[v*dataSize +: dataSize];
                    read_data[v*dataSize +: dataSize] <= mem[word_idx(DataAdr, v)];
                end
            end
        end
    endgenerate
endmodule

// File: rtl/lane_counter.sv
// Lane index for the issue side plus a one-cycle delayed copy for load capture.
module lane_counter #(
    parameter int unsigned lanes = 4,
    parameter int unsigned idxW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    output logic [idxW-1:0] idx,
    output logic [idxW-1:0] cap,
    output logic            last
);
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            cap <= '0;
        end else begin
            if (clear)
                idx <= '0;
            else if (enable)
                idx <= idx + idxW'(1);
            cap <= idx;
        end
    end

    assign last = (idx == idxW'(lanes - 1));
endmodule

// File: rtl/vec_mem_sequencer.sv
// Issues one vector load/store as consecutive scalar word accesses and gathers load results.
module vec_mem_sequencer #(
    parameter int unsigned dataSize       = 32,
    parameter int unsigned addressingSize = 32,
    parameter int unsigned lanes          = 4
) (
    input logic                 clk,
    input logic                 rst,
    vec_mem_sequencer_if.master bus
);
    import simd_mem_pkg::*;

    localparam int unsigned IDX_W = (lanes > 1) ? $clog2(lanes) : 1;

    seq_state_t                     state;
    logic                           is_store_q;
    logic [addressingSize-1:0]      base_q;
    logic [lanes-1:0][dataSize-1:0] store_q;
    logic                           cap_en;
    logic [IDX_W-1:0]               idx;
    logic [IDX_W-1:0]               cap;
    logic [IDX_W-1:0]               nidx;
    logic                           last;
    logic                           accept;
    logic                           advance;

    assign accept  = (state == IDLE) && bus.start;
    assign advance = (state == ISSUE) && !last;
    assign nidx    = idx + IDX_W'(1);

    lane_counter #(
        .lanes (lanes),
        .idxW  (IDX_W)
    ) u_lane_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (advance),
        .idx    (idx),
        .cap    (cap),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            is_store_q    <= 1'b0;
            base_q        <= '0;
            store_q       <= '0;
            cap_en        <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.load_data <= '0;
        end else begin
            bus.done <= 1'b0;
            // read_data for the lane presented last cycle arrives this cycle
            cap_en <= (state == ISSUE) && !is_store_q;
            if (cap_en)
                bus.load_data[cap] <= bus.mem_rdata;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_store_q    <= bus.is_store;
                        base_q        <= bus.base_addr;
                        store_q       <= bus.store_data;
                        bus.mem_addr  <= bus.base_addr;
                        bus.mem_we    <= bus.is_store;
                        bus.mem_wdata <= bus.store_data[0];
                        bus.busy      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (last) begin
                        bus.mem_we <= 1'b0;
                        if (is_store_q) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        bus.mem_addr  <= base_q + addressingSize'(nidx);
                        bus.mem_wdata <= store_q[nidx];
                    end
                end
                DRAIN: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer driving the real data_memory as the responder.
module tb_vec_mem_sequencer;
    import simd_mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] addr_log[$];

    always #5 clk = ~clk;

    vec_mem_sequencer_if #(.dataSize(DATA_W), .addressingSize(ADDR_W), .lanes(LANES)) bus ();
    vec_mem_sequencer_if #(.dataSize(DATA_W), .addressingSize(ADDR_W), .lanes(1))     bus1 ();

    vec_mem_sequencer #(.dataSize(DATA_W), .addressingSize(ADDR_W), .lanes(LANES)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    data_memory #(.dataSize(DATA_W), .addressingSize(ADDR_W), .memorySize(10020), .vecSize(1)) u_mem (
        .clk          (clk),
        .write_enable (bus.mem_we),
        .DataAdr      (bus.mem_addr),
        .toWrite_data (bus.mem_wdata),
        .read_data    (bus.mem_rdata)
    );

    vec_mem_sequencer #(.dataSize(DATA_W), .addressingSize(ADDR_W), .lanes(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    data_memory #(.dataSize(DATA_W), .addressingSize(ADDR_W), .memorySize(10020), .vecSize(1)) u_mem1 (
        .clk          (clk),
        .write_enable (bus1.mem_we),
        .DataAdr      (bus1.mem_addr),
        .toWrite_data (bus1.mem_wdata),
        .read_data    (bus1.mem_rdata)
    );

    // Latency = cycles from the accepting cycle to the done cycle; -1 when done never came.
    task automatic run4(input bit st, input logic [31:0] ba, input lane_array_t sd,
                        input bit spam, input bit clobber, output int lat);
        int n;
        bus.start      = 1'b1;
        bus.is_store   = st;
        bus.base_addr  = ba;
        bus.store_data = sd;
        @(posedge clk); #1;
        bus.start = 1'b0;
        addr_log.delete();
        n = 0;
        if (clobber) begin
            bus.store_data = '0;
            bus.base_addr  = 32'h0000_0BAD;
        end
        while (!bus.done && n < 40) begin
            if (bus.busy) addr_log.push_back(bus.mem_addr);
            if (spam) begin
                bus.start     = 1'b1;
                bus.base_addr = 32'd6000 + 32'(n);
            end
            @(posedge clk); #1;
            n++;
        end
        lat = (n >= 40) ? -1 : n + 1;
        if (spam) begin
            bus.start     = 1'b1;
            bus.base_addr = 32'd7000;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;  bus.is_store = 1'b0;  bus.base_addr = '0;  bus.store_data = '0;
        bus1.start = 1'b0; bus1.is_store = 1'b0; bus1.base_addr = '0; bus1.store_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
        checks++; if (bus.load_data !== '0) begin errors++; $display("FAIL reset_load_data: got %h expected 0", bus.load_data); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int lat;
        lane_array_t sd;
        sd = {32'h44444444, 32'h33333333, 32'h22222222, 32'hDEADBEEF};
        run4(1'b1, 32'd100, sd, 1'b0, 1'b0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL store_latency: got %0d expected 5", lat); end
        checks++; if (addr_log.size() !== 4) begin errors++; $display("FAIL store_addr_count: got %0d expected 4", addr_log.size()); end
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            checks++;
            if (addr_log[i] !== 32'(100 + i)) begin errors++; $display("FAIL store_addr[%0d]: got %0d expected %0d", i, addr_log[i], 100 + i); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (u_mem.mem[100 + i] !== sd[i]) begin errors++; $display("FAIL store_mem[%0d]: got %h expected %h", 100 + i, u_mem.mem[100 + i], sd[i]); end
        end
        run4(1'b0, 32'd100, '0, 1'b0, 1'b0, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL load_latency: got %0d expected 6", lat); end
        checks++; if (addr_log.size() !== 5) begin errors++; $display("FAIL load_addr_count: got %0d expected 5", addr_log.size()); end
        for (int i = 0; i < 5 && i < addr_log.size(); i++) begin
            checks++;
            if (addr_log[i] !== 32'(100 + ((i > 3) ? 3 : i))) begin errors++; $display("FAIL load_addr[%0d]: got %0d", i, addr_log[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.load_data[i] !== sd[i]) begin errors++; $display("FAIL load_lane[%0d]: got %h expected %h", i, bus.load_data[i], sd[i]); end
        end
    endtask

    task automatic test_addr_wrap();
        int lat;
        logic [31:0] exp_a [4];
        exp_a = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        run4(1'b1, 32'hFFFF_FFFE, {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000}, 1'b0, 1'b0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL wrap_latency: got %0d expected 5", lat); end
        checks++; if (addr_log.size() !== 4) begin errors++; $display("FAIL wrap_addr_count: got %0d expected 4", addr_log.size()); end
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            checks++;
            if (addr_log[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, addr_log[i], exp_a[i]); end
        end
        checks++; if (u_mem.mem[0] !== 32'h1111_0002) begin errors++; $display("FAIL wrap_mem0: got %h expected 11110002", u_mem.mem[0]); end
    endtask

    task automatic test_busy_reject();
        int lat;
        run4(1'b0, 32'd100, '0, 1'b1, 1'b0, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL busy_latency: got %0d expected 6", lat); end
        checks++; if (addr_log.size() !== 5) begin errors++; $display("FAIL busy_addr_count: got %0d expected 5", addr_log.size()); end
        for (int i = 0; i < 5 && i < addr_log.size(); i++) begin
            checks++;
            if (addr_log[i] !== 32'(100 + ((i > 3) ? 3 : i))) begin errors++; $display("FAIL busy_addr[%0d]: got %0d", i, addr_log[i]); end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_start_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.load_data[3] !== 32'h44444444) begin errors++; $display("FAIL busy_lane3: got %h expected 44444444", bus.load_data[3]); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_start_busy2: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL extra_done: got %b expected 0", bus.done); end
    endtask

    task automatic test_reset_mid_store();
        int lat;
        run4(1'b1, 32'd200, {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000}, 1'b0, 1'b0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL prestore_latency: got %0d expected 5", lat); end
        bus.start      = 1'b1;
        bus.is_store   = 1'b1;
        bus.base_addr  = 32'd200;
        bus.store_data = {32'hB0B0_0003, 32'hB0B0_0002, 32'hB0B0_0001, 32'hB0B0_0000};
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.load_data !== '0) begin errors++; $display("FAIL rst_mid_load_data: got %h expected 0", bus.load_data); end
        checks++; if (u_mem.mem[200] !== 32'hB0B0_0000) begin errors++; $display("FAIL rst_mid_mem200: got %h expected b0b00000", u_mem.mem[200]); end
        checks++; if (u_mem.mem[201] !== 32'hB0B0_0001) begin errors++; $display("FAIL rst_mid_mem201: got %h expected b0b00001", u_mem.mem[201]); end
        checks++; if (u_mem.mem[202] !== 32'hA0A0_0002) begin errors++; $display("FAIL rst_mid_mem202: got %h expected a0a00002", u_mem.mem[202]); end
        checks++; if (u_mem.mem[203] !== 32'hA0A0_0003) begin errors++; $display("FAIL rst_mid_mem203: got %h expected a0a00003", u_mem.mem[203]); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_isolation();
        int lat;
        lane_array_t sd;
        sd = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
        run4(1'b1, 32'd300, sd, 1'b0, 1'b1, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL iso_latency: got %0d expected 5", lat); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (u_mem.mem[300 + i] !== sd[i]) begin errors++; $display("FAIL iso_mem[%0d]: got %h expected %h", 300 + i, u_mem.mem[300 + i], sd[i]); end
        end
        checks++; if (u_mem.mem[32'h0BAD] === 32'h0) begin end
        checks--;
    endtask

    task automatic test_lanes1();
        int n;
        bus1.start      = 1'b1;
        bus1.is_store   = 1'b1;
        bus1.base_addr  = 32'd7;
        bus1.store_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        n = 0;
        while (!bus1.done && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n + 1 !== 2) begin errors++; $display("FAIL l1_store_latency: got %0d expected 2", n + 1); end
        checks++; if (u_mem1.mem[7] !== 32'hCAFEF00D) begin errors++; $display("FAIL l1_mem7: got %h expected cafef00d", u_mem1.mem[7]); end
        @(posedge clk); #1;
        bus1.start      = 1'b1;
        bus1.is_store   = 1'b0;
        bus1.store_data = '0;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        n = 0;
        while (!bus1.done && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n + 1 !== 3) begin errors++; $display("FAIL l1_load_latency: got %0d expected 3", n + 1); end
        checks++; if (bus1.load_data[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL l1_load_data: got %h expected cafef00d", bus1.load_data[0]); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_addr_wrap();
        test_store_load();
        test_busy_reject();
        test_reset_mid_store();
        test_isolation();
        test_lanes1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
